// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    localparam logic UART_IDLE_LVL      = 1'b1;
    localparam int   UART_MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DELIVER,
        BREAK
    } rx_state_t;

    function automatic int bps_cnt(input int sys_clk_fre, input int bps);
        return sys_clk_fre / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous RX pin plus falling-edge detect.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic uart_rxd,
    output logic rxd_s,
    output logic rxd_fall
);

    logic rxd_meta;
    logic rxd_prev;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rxd_meta <= UART_IDLE_LVL;
            rxd_s    <= UART_IDLE_LVL;
            rxd_prev <= UART_IDLE_LVL;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign rxd_fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with error flags and a one-entry valid/ready holding register.
// Optional parity bit is compiled in with the UART_RX_PARITY_EN macro.
//
// state   | meaning
// IDLE    | line idle, waiting for a falling edge
// START   | confirming the start bit at mid-bit
// DATA    | shifting in DATA_BITS payload bits, LSB first
// PARITY  | checking the parity bit (UART_RX_PARITY_EN only)
// STOP    | sampling STOP_BITS stop bits
// DELIVER | one cycle: hand the frame to the holding register
// BREAK   | line held low after the frame; wait for it to go high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FRE = 50_000_000,
    parameter int BPS         = 115200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_rx_valid,
    input  logic                 uart_rx_ready,
    output logic                 uart_rx_frame_err,
    output logic                 uart_rx_parity_err,
    output logic                 uart_rx_overrun,
    output logic                 uart_rx_busy
);

    localparam int BPS_CNT = bps_cnt(SYS_CLK_FRE, BPS);
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] MID_CNT   = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] TOP_CNT   = CNT_W'(BPS_CNT - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    rx_state_t            state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 frm_err;
    logic                 rxd_s;
    logic                 rxd_fall;
    logic                 sample;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_POL = 1'(PARITY_ODD);
    logic par_err;
`else
    logic unused_parity_odd;
    assign unused_parity_odd  = 1'(PARITY_ODD);
    assign uart_rx_parity_err = 1'b0;
`endif

    uart_rx_sync u_sync (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .uart_rxd  (uart_rxd),
        .rxd_s     (rxd_s),
        .rxd_fall  (rxd_fall)
    );

    // Every sampling point sits at mid-bit because clk_cnt starts at the start-bit edge.
    assign sample       = (clk_cnt == MID_CNT);
    assign uart_rx_busy = (state != IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state             <= IDLE;
            clk_cnt           <= '0;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            frm_err           <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err            <= 1'b0;
            uart_rx_parity_err <= 1'b0;
`endif
        end else begin
            uart_rx_overrun <= 1'b0;
            if (uart_rx_valid && uart_rx_ready) begin
                uart_rx_valid <= 1'b0;
            end

            if (state == IDLE || state == DELIVER || state == BREAK) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= (clk_cnt == TOP_CNT) ? '0 : clk_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rxd_fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                        frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_err <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (sample) begin
                        state <= rxd_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {rxd_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        par_err <= rxd_s ^ (^shift_reg) ^ PAR_POL;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        if (!rxd_s) begin
                            frm_err <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            state <= DELIVER;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    // A pending frame being accepted this cycle frees the slot for the new one.
                    if (!uart_rx_valid || uart_rx_ready) begin
                        uart_rx_data      <= shift_reg;
                        uart_rx_frame_err <= frm_err;
                        uart_rx_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        uart_rx_parity_err <= par_err;
`endif
                    end else begin
                        uart_rx_overrun <= 1'b1;
                    end
                    state <= rxd_s ? IDLE : BREAK;
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: table-driven frames with a scoreboard plus corner sequences.
module tb_uart_rx_param;

    localparam int SYS_CLK_FRE = 50_000_000;
    localparam int BPS         = 3_125_000;   // 16 clocks per bit
    localparam int BIT_T       = 320;         // 16 clocks of 20 time units
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    localparam logic PAR_ODD = 1'b0;
    localparam int   NV      = 8;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_lvl;
        int         hold;
        logic       par_flip;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       sys_clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic       rxd_a, rxd_b, ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, ferr_a, perr_a, ovr_a, busy_a;
    logic       valid_b, ferr_b, perr_b, ovr_b, busy_b;

    int   errors = 0;
    int   checks = 0;
    int   deliveries = 0;
    int   ovr_seen = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[NV];

    always #10 sys_clk = ~sys_clk;

    uart_rx_param #(
        .SYS_CLK_FRE(SYS_CLK_FRE), .BPS(BPS), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_a (
        .sys_clk            (sys_clk),
        .sys_rst_n          (rst_a_n),
        .uart_rxd           (rxd_a),
        .uart_rx_data       (data_a),
        .uart_rx_valid      (valid_a),
        .uart_rx_ready      (ready_a),
        .uart_rx_frame_err  (ferr_a),
        .uart_rx_parity_err (perr_a),
        .uart_rx_overrun    (ovr_a),
        .uart_rx_busy       (busy_a)
    );

    uart_rx_param #(
        .SYS_CLK_FRE(SYS_CLK_FRE), .BPS(BPS), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)
    ) dut_b (
        .sys_clk            (sys_clk),
        .sys_rst_n          (rst_b_n),
        .uart_rxd           (rxd_b),
        .uart_rx_data       (data_b),
        .uart_rx_valid      (valid_b),
        .uart_rx_ready      (ready_b),
        .uart_rx_frame_err  (ferr_b),
        .uart_rx_parity_err (perr_b),
        .uart_rx_overrun    (ovr_b),
        .uart_rx_busy       (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_lvl, input int hold,
                          input logic par_flip);
        rxd_a = 1'b0;
        #BIT_T;
        for (int i = 0; i < 8; i++) begin
            rxd_a = d[i];
            #BIT_T;
        end
        if (PAR_EN) begin
            rxd_a = (^d) ^ PAR_ODD ^ par_flip;
            #BIT_T;
        end
        rxd_a = stop_lvl;
        #(BIT_T * hold);
        rxd_a = 1'b1;
        #(BIT_T * 2);
    endtask

    task automatic send_b(input logic [6:0] d, input logic stop1, input logic stop2);
        rxd_b = 1'b0;
        #BIT_T;
        for (int i = 0; i < 7; i++) begin
            rxd_b = d[i];
            #BIT_T;
        end
        if (PAR_EN) begin
            rxd_b = (^d) ^ PAR_ODD;
            #BIT_T;
        end
        rxd_b = stop1;
        #BIT_T;
        rxd_b = stop2;
        #BIT_T;
        rxd_b = 1'b1;
        #(BIT_T * 2);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 2000 && sb_q.size() > 0; i++) @(posedge sys_clk);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    // Scoreboard monitor: compares every accepted frame of dut_a against the expected queue.
    always @(negedge sys_clk) begin
        if (rst_a_n) begin
            if (ovr_a) ovr_seen++;
            if (valid_a && ready_a) begin
                deliveries++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got frame %0h, expected none", data_a);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", data_a, mon_e.data);
                    check("sb_frame_err", ferr_a, mon_e.ferr);
                    check("sb_parity_err", perr_a, mon_e.perr);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   lat_exp;
        logic got;
        int   d0;
        int   o0;

        vecs[0] = '{8'hA3, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b1, 1, 1'b1, 1'b0, PAR_EN};
        vecs[6] = '{8'h3C, 1'b0, 1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h01, 1'b1, 1, 1'b1, 1'b0, PAR_EN};

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        rxd_a = 1'b1;   rxd_b = 1'b1;
        ready_a = 1'b1; ready_b = 1'b0;
        repeat (4) @(posedge sys_clk);
        #1;
        check("rst_data", data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_frame_err", ferr_a, 0);
        check("rst_parity_err", perr_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_b_valid", valid_b, 0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;

        // Single clean frame: latency and one-cycle valid pulse.
        sb_q.push_back('{8'h55, 1'b0, 1'b0});
        lat = 0;
        got = 1'b0;
        lat_exp = 156 + 16 * int'(PAR_EN);
        fork
            send_a(8'h55, 1'b1, 1, 1'b0);
            begin
                for (int i = 0; i < 400 && !got; i++) begin
                    @(posedge sys_clk);
                    #1;
                    lat++;
                    if (valid_a) got = 1'b1;
                end
                check("t1_valid_seen", got, 1);
                check("t1_latency_window", (lat >= lat_exp - 2) && (lat <= lat_exp + 2), 1);
                @(posedge sys_clk);
                #1;
                check("t1_valid_one_cycle", valid_a, 0);
            end
        join

        // Start glitch shorter than half a bit is rejected.
        @(posedge sys_clk);
        #1;
        d0 = deliveries;
        rxd_a = 1'b0;
        #100;
        rxd_a = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("t2_busy_in_start", busy_a, 1);
        repeat (12) @(posedge sys_clk);
        #1;
        check("t2_back_to_idle", busy_a, 0);
        check("t2_no_delivery", deliveries, d0);

        // Low stop bit held for 3 bit times: framing error, then BREAK until line high.
        sb_q.push_back('{8'h0F, 1'b1, 1'b0});
        d0 = deliveries;
        fork
            send_a(8'h0F, 1'b0, 3, 1'b0);
            begin
                #(BIT_T * (11 + int'(PAR_EN)));
                check("t3_busy_in_break", busy_a, 1);
                check("t3_delivered", deliveries, d0 + 1);
            end
        join
        check("t3_break_released", busy_a, 0);

        for (int i = 0; i < NV; i++) begin
            sb_q.push_back('{vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr});
            send_a(vecs[i].data, vecs[i].stop_lvl, vecs[i].hold, vecs[i].par_flip);
        end
        drain_a();

        // Overrun: second frame dropped while the first is still held.
        ready_a = 1'b0;
        o0 = ovr_seen;
        d0 = deliveries;
        sb_q.push_back('{8'h11, 1'b0, 1'b0});
        send_a(8'h11, 1'b1, 1, 1'b0);
        send_a(8'h22, 1'b1, 1, 1'b0);
        check("t4_overrun_pulses", ovr_seen - o0, 1);
        check("t4_valid_held", valid_a, 1);
        check("t4_data_kept", data_a, 8'h11);
        check("t4_not_consumed", deliveries, d0);
        @(posedge sys_clk);
        #1;
        ready_a = 1'b1;
        @(posedge sys_clk);
        #1;
        check("t4_valid_drops", valid_a, 0);
        check("t4_consumed", deliveries, d0 + 1);
        sb_q.push_back('{8'h5C, 1'b0, 1'b0});
        send_a(8'h5C, 1'b1, 1, 1'b0);
        drain_a();

        // 7 data bits, 2 stop bits: low second stop bit is a framing error.
        send_b(7'h5A, 1'b1, 1'b0);
        check("t6_valid", valid_b, 1);
        check("t6_data", data_b, 7'h5A);
        check("t6_frame_err", ferr_b, 1);
        check("t6_parity_err", perr_b, 0);
        @(posedge sys_clk);
        #1;
        ready_b = 1'b1;
        @(posedge sys_clk);
        #1;
        ready_b = 1'b0;
        check("t6_consumed", valid_b, 0);
        send_b(7'h2C, 1'b1, 1'b1);
        check("t6_clean_valid", valid_b, 1);
        check("t6_clean_data", data_b, 7'h2C);
        check("t6_clean_frame_err", ferr_b, 0);

        // Reset during data bit 3 clears the held frame and aborts the one in flight.
        fork
            send_b(7'h33, 1'b1, 1'b1);
            begin
                #(BIT_T * 4 + BIT_T / 2);
                rst_b_n = 1'b0;
                repeat (2) @(posedge sys_clk);
                #1;
                check("t6_rst_valid", valid_b, 0);
                check("t6_rst_data", data_b, 0);
                check("t6_rst_frame_err", ferr_b, 0);
                check("t6_rst_overrun", ovr_b, 0);
                check("t6_rst_busy", busy_b, 0);
            end
        join
        rst_b_n = 1'b1;
        #(BIT_T * 14);
        check("t6_no_partial_delivery", valid_b, 0);
        check("t6_idle_after_reset", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor to the fixed 8N1 UART receiver. Configurable data width, stop-bit count and parity polarity. Adds a 2-flop input synchroniser, false-start rejection, framing/parity/overrun error reporting, and a valid/ready output handshake with a one-entry holding register. Sits between the board RX pin and any byte consumer (command parser, FIFO, bus bridge).

Parameters:
SYS_CLK_FRE, 50_000_000, system clock frequency in Hz
BPS, 115200, baud rate; BPS_CNT = SYS_CLK_FRE/BPS clocks per bit (434 at defaults)
DATA_BITS, 8, payload bits per frame; legal range 5..9
STOP_BITS, 1, expected stop bits; legal values 1 or 2
PARITY_ODD, 0, parity polarity when parity is compiled in: 0 = even, 1 = odd

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
sys_rst_n  in  1  synchronous active-low reset
uart_rxd  in  1  asynchronous serial input; idle high
uart_rx_data  out  DATA_BITS  received payload, LSB first on the line
uart_rx_valid  out  1  holding register holds an unconsumed frame
uart_rx_ready  in  1  consumer accepts the frame when valid && ready
uart_rx_frame_err  out  1  qualified by valid: a stop bit was sampled low
uart_rx_parity_err  out  1  qualified by valid: parity mismatch; tied 0 without UART_RX_PARITY_EN
uart_rx_overrun  out  1  one-cycle pulse: a completed frame was dropped
uart_rx_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sys_rst_n low at a clock edge): state IDLE, counters 0, synchroniser flops 1. Outputs: data 0, valid 0, frame_err 0, parity_err 0, overrun 0, busy 0. Reset mid-frame aborts the frame; no partial data is delivered.
- Input: uart_rxd passes through two flops (rxd_s). A falling edge is rxd_s low with the previous rxd_s high.
- State machine:
  - IDLE: on a falling edge, go to START and clear the bit counter.
  - START: at clk_cnt == BPS_CNT/2-1, sample rxd_s. If 1, it is a false start; return to IDLE with no output. If 0, go to DATA.
  - DATA: sample every BPS_CNT clocks at mid-bit and shift LSB first. After DATA_BITS samples, go to PARITY (when compiled in) or to STOP.
  - PARITY: sample one bit and compare it with the XOR of the data bits XOR PARITY_ODD. A mismatch sets the parity error.
  - STOP: sample STOP_BITS bits. Any low sample sets the frame error.
  - DELIVER: one cycle. Back to IDLE, or to BREAK when rxd_s is low.
  - BREAK: wait until rxd_s is high, then go to IDLE. Falling edges are ignored here.
- clk_cnt runs 0..BPS_CNT-1 and wraps. It restarts at 0 on entry to START. Sampling points are fixed at mid-bit.
- Latency: uart_rx_valid rises on the clock edge following the final stop-bit sample, i.e. the DELIVER cycle.
- Handshake:
  - uart_rx_data and the error flags are loaded together with valid. They stay stable while valid is high.
  - valid clears on the edge where valid && ready.
  - A frame completing in the same cycle as the handshake is accepted: new data loads and valid stays 1.
  - A frame completing while valid && !ready is dropped. Data and flags are unchanged and uart_rx_overrun pulses for 1 cycle.
- Frames with frame/parity errors are still delivered; the flags qualify them. A frame error with rxd_s held low routes to BREAK.
- Width: parity is the XOR reduction over DATA_BITS bits. Counters are sized $clog2(BPS_CNT) and $clog2(DATA_BITS+1).

Optional Feature:
UART_RX_PARITY_EN:
- Defined: the PARITY state exists and one parity bit is expected after the data. uart_rx_parity_err reports a mismatch per PARITY_ODD.
- Undefined: no parity bit is expected. DATA goes straight to STOP, uart_rx_parity_err is a constant 0, and PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK}
  - function bps_cnt(sys_clk_fre, bps)
  - localparams UART_IDLE_LVL = 1'b1 and UART_MAX_DATA_BITS = 9
- Sub-module uart_rx_sync: 2-flop synchroniser plus falling-edge detect. Ports: sys_clk, sys_rst_n, uart_rxd, rxd_s, rxd_fall.
- Baud counter and FSM stay in the top module.

Test Plan:
1. Defaults, parity off: send 8'h55 at 8680 ns/bit with ready = 1. valid pulses one cycle with data = 8'h55 and frame_err = 0. valid rises within 2 clocks after the stop-bit mid-point plus sync delay.
2. Start glitch: drive rxd low for 100 ns, then high. FSM returns to IDLE and valid stays 0. A following frame 8'hA3 is received correctly.
3. Framing error: send 8'h0F with stop = 0, held low for 3 bit times. valid rises with data = 8'h0F and frame_err = 1. busy stays high until rxd returns high (BREAK). The next frame is received cleanly.
4. Overrun: hold ready = 0 and send 8'h11 then 8'h22. After the second frame, overrun pulses once and data stays 8'h11. Raise ready: valid drops the next cycle.
5. UART_RX_PARITY_EN, PARITY_ODD = 0: 8'h07 with parity bit 1 gives parity_err = 0. 8'h07 with parity bit 0 gives parity_err = 1.
6. DATA_BITS = 7, STOP_BITS = 2: send 7'h5A with a low second stop bit gives frame_err = 1. Asserting reset mid-frame (during bit 3) returns all outputs to 0 with no delivery.
